// File: rtl/reduced_precision_packer.sv
// reduced_precision_packer
// Keeps the low P bits of each accepted BIT_WIDTH-bit value and concatenates
// them LSB-first into BIT_WIDTH-bit rows. A flush drains every buffered bit,
// emitting the trailing partial row zero-padded, so value k of a packed stream
// sits at bit offset k*P for the downstream unpacker.
//
// Optional build macro: PACKER_ROW_COUNT_EN adds o_rows, a wrapping count of
// popped rows that is cleared in the cycle o_done pulses.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising edge. On the input side that is i_valid && o_ready; on
// the output side that is o_valid && i_ready. A producer holds its data stable
// while valid is high and ready is low. o_ready looks through to i_ready, so a
// full row can be popped and a new value pushed in the same cycle.
module reduced_precision_packer #(
  parameter int BIT_WIDTH = 16,
  parameter int PREC_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PREC_BITS-1:0] i_prec,
  input  logic                 i_flush,
  output logic [BIT_WIDTH-1:0] o_row,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_last,
  output logic                 o_done
`ifdef PACKER_ROW_COUNT_EN
  ,
  output logic [15:0]          o_rows
`endif
);

  localparam int AW = 2 * BIT_WIDTH;
  localparam int CW = $clog2(AW);
  localparam logic [CW-1:0]        L_BW  = CW'(BIT_WIDTH);
  localparam logic [PREC_BITS-1:0] L_BWP = PREC_BITS'(BIT_WIDTH);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AW-1:0]        r_acc;
  logic [CW-1:0]        r_cnt;
  logic [PREC_BITS-1:0] r_prec;
  logic                 r_first;
  logic                 r_done;

  logic [PREC_BITS-1:0] w_prec_in;
  logic [PREC_BITS-1:0] w_p;
  logic [BIT_WIDTH-1:0] w_mask;
  logic [BIT_WIDTH-1:0] w_data_m;
  logic                 w_valid;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_exit;
  logic [CW-1:0]        w_shamt;
  logic [AW-1:0]        w_ins;
  logic [AW-1:0]        w_acc_nxt;
  logic [CW-1:0]        w_cnt_nxt;

  // Precision select: out-of-range requests fall back to full width, and the
  // first value of a stream uses the live i_prec rather than the latched one.
  always_comb begin
    w_prec_in = i_prec;
    if ((i_prec == '0) || (i_prec > L_BWP)) w_prec_in = L_BWP;
    w_p = r_first ? w_prec_in : r_prec;
  end

  // Keep-mask for the low P bits of the incoming value.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if (i < int'(w_p)) w_mask[i] = 1'b1;
    end
    w_data_m = i_data & w_mask;
  end

  // Handshake flags; a partial row is only offered while draining.
  always_comb begin
    w_valid = (r_cnt >= L_BW) || ((r_state == S_FLUSH) && (r_cnt != '0));
    w_ready = (r_state == S_RUN) && ((r_cnt < L_BW) || i_ready);
    w_push  = i_valid && w_ready;
    w_pop   = w_valid && i_ready;
    o_valid = w_valid;
    o_ready = w_ready;
    o_last  = w_valid && (r_state == S_FLUSH) && (r_cnt <= L_BW);
    o_row   = r_acc[BIT_WIDTH-1:0];
    o_done  = r_done;
  end

  // Next-state logic: leave FLUSH once nothing is buffered.
  always_comb begin
    w_state_nxt = r_state;
    w_exit      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (i_flush) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RUN;
          w_exit      = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Accumulator update; on a simultaneous pop the new bits land below the
  // position they would have had, since the low row leaves in the same edge.
  always_comb begin
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_cnt;
    w_shamt   = w_pop ? (r_cnt - L_BW) : r_cnt;
    w_ins     = {{BIT_WIDTH{1'b0}}, w_data_m} << w_shamt;
    if (w_push && w_pop) begin
      w_acc_nxt = (r_acc >> BIT_WIDTH) | w_ins;
      w_cnt_nxt = r_cnt - L_BW + CW'(w_p);
    end else if (w_push) begin
      w_acc_nxt = r_acc | w_ins;
      w_cnt_nxt = r_cnt + CW'(w_p);
    end else if (w_pop) begin
      w_acc_nxt = r_acc >> BIT_WIDTH;
      w_cnt_nxt = (r_cnt >= L_BW) ? (r_cnt - L_BW) : '0;
    end
  end

  // State register, buffer, precision latch and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_prec  <= L_BWP;
      r_first <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_exit;
      if (w_push && r_first) begin
        r_prec  <= w_prec_in;
        r_first <= 1'b0;
      end
      if (w_exit) r_first <= 1'b1;
    end
  end

`ifdef PACKER_ROW_COUNT_EN
  logic [15:0] r_rows;

  // Popped-row counter; the clear in the done cycle follows the final row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows <= '0;
    end else if (r_done) begin
      r_rows <= '0;
    end else if (w_pop) begin
      r_rows <= r_rows + 16'd1;
    end
  end

  assign o_rows = r_rows;
`endif

endmodule

// File: tb/tb_reduced_precision_packer.sv
// Directed bench for reduced_precision_packer (BIT_WIDTH=16, PREC_BITS=5).
// Inputs change 1 time unit after the rising edge; outputs are checked 2 time
// units later, well away from the next edge.
module tb_reduced_precision_packer;

  logic        clk;
  logic        rst;
  logic [15:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_prec;
  logic        i_flush;
  logic [15:0] o_row;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic        o_done;
`ifdef PACKER_ROW_COUNT_EN
  logic [15:0] o_rows;
`endif

  int n_pass  = 0;
  int n_total = 0;

  reduced_precision_packer #(.BIT_WIDTH(16), .PREC_BITS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_prec  (i_prec),
    .i_flush (i_flush),
    .o_row   (o_row),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_last  (o_last),
    .o_done  (o_done)
`ifdef PACKER_ROW_COUNT_EN
    ,
    .o_rows  (o_rows)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] p,
                       input logic r, input logic f);
    i_valid = v;
    i_data  = d;
    i_prec  = p;
    i_ready = r;
    i_flush = f;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Pulse flush from an idle RUN cycle and wait (bounded) for o_done.
  task automatic flush_and_wait(input string tag);
    int k;
    i_valid = 1'b0;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    k = 0;
    while (o_done !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, o_done}, 32'd1);
    tick();
  endtask

  initial begin
    drive(1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();

    // reset state
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_last",  {31'd0, o_last},  32'd0);
    chk("rst_done",  {31'd0, o_done},  32'd0);
    chk("rst_row",   {16'd0, o_row},   32'h0000);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
`ifdef PACKER_ROW_COUNT_EN
    chk("rst_rows",  {16'd0, o_rows},  32'd0);
`endif

    // P=16, one row per push, no stall
    drive(1'b1, 16'h1234, 5'd16, 1'b1, 1'b0); settle();
    chk("p16_ready0", {31'd0, o_ready}, 32'd1);
    chk("p16_valid0", {31'd0, o_valid}, 32'd0);
    tick();
    drive(1'b1, 16'hABCD, 5'd16, 1'b1, 1'b0); settle();
    chk("p16_valid1", {31'd0, o_valid}, 32'd1);
    chk("p16_row1",   {16'd0, o_row},   32'h1234);
    chk("p16_ready1", {31'd0, o_ready}, 32'd1);
    tick();
    drive(1'b0, 16'h0000, 5'd16, 1'b1, 1'b0); settle();
    chk("p16_valid2", {31'd0, o_valid}, 32'd1);
    chk("p16_row2",   {16'd0, o_row},   32'hABCD);
    chk("p16_last2",  {31'd0, o_last},  32'd0);
    tick();
    settle();
    chk("p16_valid3", {31'd0, o_valid}, 32'd0);
`ifdef PACKER_ROW_COUNT_EN
    chk("p16_rows", {16'd0, o_rows}, 32'd2);
`endif
    flush_and_wait("p16_done");

    // P=4, upper bits of the first value are masked away
    drive(1'b1, 16'hFFF1, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h0002, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h0003, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h0004, 5'd4, 1'b1, 1'b0); settle();
    chk("p4_valid_pre", {31'd0, o_valid}, 32'd0);
    tick();
    drive(1'b0, 16'h0000, 5'd4, 1'b1, 1'b0); settle();
    chk("p4_valid", {31'd0, o_valid}, 32'd1);
    chk("p4_row",   {16'd0, o_row},   32'h4321);
    chk("p4_last",  {31'd0, o_last},  32'd0);
    tick();
    flush_and_wait("p4_done");

    // P=5 with a partial trailing row
    drive(1'b1, 16'h001F, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h0000, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h001F, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h0015, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b0, 16'h0000, 5'd5, 1'b1, 1'b1); settle();
    chk("p5_valid0", {31'd0, o_valid}, 32'd1);
    chk("p5_row0",   {16'd0, o_row},   32'hFC1F);
    chk("p5_last0",  {31'd0, o_last},  32'd0);
    tick();
    i_flush = 1'b0; settle();
    chk("p5_valid1", {31'd0, o_valid}, 32'd1);
    chk("p5_row1",   {16'd0, o_row},   32'h000A);
    chk("p5_last1",  {31'd0, o_last},  32'd1);
    chk("p5_ready1", {31'd0, o_ready}, 32'd0);
    tick();
    settle();
    chk("p5_valid2", {31'd0, o_valid}, 32'd0);
    chk("p5_done2",  {31'd0, o_done},  32'd0);
`ifdef PACKER_ROW_COUNT_EN
    chk("p5_rows2", {16'd0, o_rows}, 32'd2);
`endif
    tick();
    settle();
    chk("p5_done3", {31'd0, o_done}, 32'd1);
    tick();
    settle();
    chk("p5_done4", {31'd0, o_done}, 32'd0);
`ifdef PACKER_ROW_COUNT_EN
    chk("p5_rows4", {16'd0, o_rows}, 32'd0);
`endif

    // backpressure at P=8
    drive(1'b1, 16'h0011, 5'd8, 1'b0, 1'b0); settle();
    chk("bp_ready0", {31'd0, o_ready}, 32'd1);
    tick();
    drive(1'b1, 16'h0022, 5'd8, 1'b0, 1'b0); settle();
    chk("bp_ready1", {31'd0, o_ready}, 32'd1);
    chk("bp_valid1", {31'd0, o_valid}, 32'd0);
    tick();
    drive(1'b1, 16'h0033, 5'd8, 1'b0, 1'b0); settle();
    chk("bp_ready2", {31'd0, o_ready}, 32'd0);
    chk("bp_valid2", {31'd0, o_valid}, 32'd1);
    chk("bp_row2",   {16'd0, o_row},   32'h2211);
    tick();
    settle();
    chk("bp_ready3", {31'd0, o_ready}, 32'd0);
    chk("bp_row3",   {16'd0, o_row},   32'h2211);
    i_ready = 1'b1; settle();
    chk("bp_ready4", {31'd0, o_ready}, 32'd1);
    chk("bp_row4",   {16'd0, o_row},   32'h2211);
    tick();
    drive(1'b1, 16'h0044, 5'd8, 1'b1, 1'b0); settle();
    chk("bp_valid5", {31'd0, o_valid}, 32'd0);
    chk("bp_ready5", {31'd0, o_ready}, 32'd1);
    tick();
    drive(1'b0, 16'h0000, 5'd8, 1'b1, 1'b0); settle();
    chk("bp_valid6", {31'd0, o_valid}, 32'd1);
    chk("bp_row6",   {16'd0, o_row},   32'h4433);
    tick();
    settle();
    chk("bp_valid7", {31'd0, o_valid}, 32'd0);
    flush_and_wait("bp_done");

    // empty flush, then a precision change 4 -> 8 takes effect
    drive(1'b1, 16'h0005, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h0006, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h0007, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h0008, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b0, 16'h0000, 5'd4, 1'b1, 1'b0); settle();
    chk("ef_row", {16'd0, o_row}, 32'h8765);
    tick();
    drive(1'b0, 16'h0000, 5'd8, 1'b1, 1'b1); settle();
    chk("ef_valid0", {31'd0, o_valid}, 32'd0);
    tick();
    i_flush = 1'b0; settle();
    chk("ef_valid1", {31'd0, o_valid}, 32'd0);
    chk("ef_ready1", {31'd0, o_ready}, 32'd0);
    chk("ef_done1",  {31'd0, o_done},  32'd0);
    tick();
    settle();
    chk("ef_done2",  {31'd0, o_done},  32'd1);
    chk("ef_valid2", {31'd0, o_valid}, 32'd0);
    tick();
    drive(1'b1, 16'h00AB, 5'd8, 1'b1, 1'b0); settle();
    chk("ef_done3", {31'd0, o_done}, 32'd0);
    tick();
    drive(1'b1, 16'h00CD, 5'd8, 1'b1, 1'b0); tick();
    drive(1'b0, 16'h0000, 5'd8, 1'b1, 1'b0); settle();
    chk("ef_valid4", {31'd0, o_valid}, 32'd1);
    chk("ef_row4",   {16'd0, o_row},   32'hCDAB);
    tick();
    flush_and_wait("ef_done_end");

    // reset mid-row discards the buffered bits
    drive(1'b1, 16'hFFFF, 5'd11, 1'b1, 1'b0); tick();
    drive(1'b0, 16'h0000, 5'd11, 1'b1, 1'b0);
    rst = 1'b1; settle();
    chk("mr_valid_pre", {31'd0, o_valid}, 32'd0);
    tick();
    rst = 1'b0; settle();
    chk("mr_valid", {31'd0, o_valid}, 32'd0);
    chk("mr_ready", {31'd0, o_ready}, 32'd1);
    chk("mr_row",   {16'd0, o_row},   32'h0000);
`ifdef PACKER_ROW_COUNT_EN
    chk("mr_rows", {16'd0, o_rows}, 32'd0);
`endif
    drive(1'b1, 16'h5A5A, 5'd16, 1'b1, 1'b0); tick();
    drive(1'b0, 16'h0000, 5'd16, 1'b1, 1'b0); settle();
    chk("mr_valid1", {31'd0, o_valid}, 32'd1);
    chk("mr_row1",   {16'd0, o_row},   32'h5A5A);
    tick();
    settle();
    chk("mr_valid2", {31'd0, o_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reduced_precision_packer.md
Name: reduced_precision_packer

Overview:
- Write-path stage that feeds unpacker-format memory rows.
- Accepts one BIT_WIDTH-bit value per handshake and keeps only its low P bits, where P is the programmed precision.
- Concatenates the kept bits LSB-first into contiguous BIT_WIDTH-bit rows and emits each row when it fills.
- On flush, emits the trailing partial row zero-padded, so the downstream unpacker can recover value k at bit offset k*P.

Parameters:
- BIT_WIDTH, 16, width of input values and output rows.
- PREC_BITS, 5, width of precision input; must satisfy 2^PREC_BITS > BIT_WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- i_data  input  BIT_WIDTH  value to pack; bits at and above P are ignored.
- i_valid  input  1  i_data valid.
- o_ready  output  1  packer accepts i_data this cycle.
- i_prec  input  PREC_BITS  precision P, 1..BIT_WIDTH; 0 or >BIT_WIDTH treated as BIT_WIDTH.
- i_flush  input  1  pulse: drain all buffered bits.
- o_row  output  BIT_WIDTH  packed row.
- o_valid  output  1  o_row valid.
- i_ready  input  1  downstream accepts o_row.
- o_last  output  1  o_row is final row of a flush.
- o_done  output  1  one-cycle pulse: flush complete.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Internal state:
  - acc: 2*BIT_WIDTH-bit accumulator.
  - cnt: fill count, 0..2*BIT_WIDTH-1.
  - prec_r: latched precision.
  - first: flag.
  - state: RUN or FLUSH.
- Reset: acc=0, cnt=0, prec_r=BIT_WIDTH, first=1, state=RUN. Outputs o_valid=0, o_last=0, o_done=0, o_row=0, o_ready=1. Reset mid-row discards buffered bits with no output.
- Precision latch: on an accepted value while first=1, prec_r<=sanitised i_prec (same-cycle value uses it) and first<=0. i_prec is ignored otherwise until flush completes.
- Masking: mask(d) = d with bits [BIT_WIDTH-1:P] cleared.
- o_row = acc[BIT_WIDTH-1:0], driven directly from the register.
- o_valid = (cnt>=BIT_WIDTH) || (state==FLUSH && cnt>0).
- o_last = o_valid && state==FLUSH && cnt<=BIT_WIDTH.
- pop = o_valid && i_ready.
- o_ready = (state==RUN) && (cnt<BIT_WIDTH || i_ready). This is combinational ready-through from i_ready; it sustains one value per cycle at P=BIT_WIDTH.
- push = i_valid && o_ready.
- Update rules:
  - push only: acc |= mask(d)<<cnt; cnt+=P.
  - pop only: acc >>= BIT_WIDTH; cnt-=BIT_WIDTH (cnt<BIT_WIDTH in FLUSH: cnt<=0).
  - push and pop: acc = (acc>>BIT_WIDTH) | mask(d)<<(cnt-BIT_WIDTH); cnt = cnt-BIT_WIDTH+P.
  - cnt never exceeds 2*BIT_WIDTH-1 because P<=BIT_WIDTH.
- Latency: a row is valid the cycle after the push that fills it. o_row and o_valid are held stable while i_ready=0.
- FSM:
  - RUN -> FLUSH on i_flush. A push in the same cycle is applied first; i_flush while in FLUSH is ignored.
  - FLUSH: no pushes. Full rows drain first, then the partial row (upper bits zero). The row whose pop leaves cnt=0 carries o_last=1.
  - FLUSH -> RUN when cnt==0 with no pending pop. On this exit, first<=1, and o_done pulses the following cycle.
  - Flush with cnt=0: no row, no o_last; FLUSH lasts 1 cycle, then o_done.

Optional Feature:
- Macro PACKER_ROW_COUNT_EN.
- With it defined:
  - Extra output o_rows[15:0] counts popped rows, wrapping at 16'hFFFF->0.
  - Reset to 0 by rst; cleared in the cycle o_done pulses.
  - An o_last row is counted before the clear.
- Without it: port and counter absent; all other behaviour identical.

Test Plan:
- P=16, i_ready=1, push 0x1234,0xABCD on consecutive cycles -> o_ready stays 1; o_row=0x1234 then 0xABCD on consecutive cycles, each one cycle after its push.
- P=4, push 0xFFF1,0x2,0x3,0x4 -> single row 0x4321 (upper bits of 0xFFF1 masked), o_last=0.
- P=5, push 0x1F,0x00,0x1F,0x15, then i_flush -> rows 0xFC1F (o_last=0) then 0x000A (o_last=1); o_done pulses once, one cycle after the last pop.
- Backpressure: P=8, push 4 values with i_ready=0 -> o_ready drops after 2 values (cnt=16); o_row=first row held stable; raising i_ready resumes push-and-pop every cycle.
- i_flush with cnt=0 -> no o_valid; o_done pulses 2 cycles after the flush; next push relatches i_prec (change 4->8 takes effect).
- Assert rst with cnt=11 mid-row -> o_valid=0, o_ready=1 next cycle; subsequent P=16 push 0x5A5A -> row 0x5A5A with no stale bits. With PACKER_ROW_COUNT_EN: o_rows=0 after reset.
